// File: rtl/aes_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_loader
// Brief    : Packs a host byte stream into 32-bit words, writes them to data
//            memory, then releases the processor from reset.
// Revision : 1.0 - initial release
// ============================================================================
module aes_loader #(
    parameter int          ADDR_W    = 12,
    parameter int          WORDS     = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done
);

    localparam int                c_word_cnt_w = $clog2(WORDS + 1);
    localparam logic [ADDR_W-1:0] c_base_addr  = ADDR_W'(BASE_ADDR);
    localparam logic [c_word_cnt_w-1:0] c_last_word = c_word_cnt_w'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_byte_cnt;
    logic [c_word_cnt_w-1:0] r_word_cnt;
    logic [23:0]             r_assembly;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic                    r_cpu_rst;
    logic                    r_done;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_last_byte;
    logic                    w_last_word;

    // Masking with rst keeps in_ready low for the whole reset window.
    assign w_ready     = (r_state == ST_LOAD) && !rst;
    assign w_accept    = in_valid && w_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_word = (r_word_cnt == c_last_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && w_last_byte) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_next = w_last_word ? ST_RUN : ST_LOAD;
            end
            ST_RUN: begin
                if (reload) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    // Outputs are registered from the next state so they align with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= '0;
            r_assembly  <= 24'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= c_base_addr;
            r_mem_wdata <= 32'd0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_mem_we  <= (w_state_next == ST_WRITE);
            r_cpu_rst <= (w_state_next != ST_RUN);
            r_done    <= (w_state_next == ST_RUN);

            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_assembly <= {r_assembly[15:0], in_data};
                if (w_last_byte) begin
                    r_mem_wdata <= {r_assembly, in_data};
                    r_mem_addr  <= c_base_addr + ADDR_W'(r_word_cnt);
                end
            end

            if (r_state == ST_WRITE) begin
                r_word_cnt <= r_word_cnt + c_word_cnt_w'(1);
            end

            if ((r_state == ST_RUN) && reload) begin
                r_byte_cnt <= 2'd0;
                r_word_cnt <= '0;
                r_assembly <= 24'd0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;

endmodule
`default_nettype wire
